gps_ca_code_gen: RTL and testbench

Upstream code-generation stage that feeds the GPS AXI4-lite register block. It produces the GPS L1 C/A Gold code for a selected satellite (PRN 1..37). The code comes from two 10-stage LFSRs (G1, G2), advanced one chip per chip-enable strobe from the 1.023 MHz clock-enable path. The first CA_BITS chips are packed into a word that software reads through the CA code register. The live chip stream and the epoch marker are also exported for downstream consumers.

---
 rtl/gps_ca_pkg.sv | 31 +++
 rtl/gps_ca_lfsr.sv | 36 +++
 rtl/gps_ca_code_gen.sv | 120 ++++++++++++
 tb/tb_gps_ca_code_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gps_ca_pkg.sv
// Shared types and constants for the GPS L1 C/A code generator.
// Tap pairs follow the ICD-GPS-200 G2 phase-select assignment for PRN 1..37.
package gps_ca_pkg;

  localparam int MAX_PRN  = 37;
  localparam int CODE_LEN = 1023;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] tap_a;
    logic [3:0] tap_b;
  } tap_pair_t;

  // One byte per PRN: upper nibble tap_a, lower nibble tap_b (G2 stage numbers 1..10).
  localparam logic [7:0] PRN_TAPS [MAX_PRN] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29, 8'h3A, 8'h23,
    8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A, 8'h14, 8'h25, 8'h36, 8'h47,
    8'h58, 8'h69, 8'h13, 8'h46, 8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27,
    8'h38, 8'h49, 8'h5A, 8'h4A, 8'h17, 8'h28, 8'h4A
  };

  function automatic tap_pair_t prn_taps(input logic [5:0] prn);
    return tap_pair_t'(PRN_TAPS[6'(prn - 6'd1)]);
  endfunction

endpackage

// File: rtl/gps_ca_lfsr.sv
// G1/G2 Gold-code LFSR pair with stage 10 as output and feedback into stage 1.
// The chip is G1[10] xor the two PRN-selected G2 stages.
module gps_ca_lfsr
  import gps_ca_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_load,
  input  logic      i_shift,
  input  tap_pair_t i_taps,
  output logic      o_chip,
  output logic      o_all_ones
);

  logic [10:1] r_g1;
  logic [10:1] r_g2;
  logic        w_fb1;
  logic        w_fb2;

  assign w_fb1 = r_g1[3] ^ r_g1[10];
  assign w_fb2 = r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_g1 <= '1;
      r_g2 <= '1;
    end else if (i_shift) begin
      r_g1 <= {r_g1[9:1], w_fb1};
      r_g2 <= {r_g2[9:1], w_fb2};
    end
  end

  assign o_chip     = r_g1[10] ^ r_g2[i_taps.tap_a] ^ r_g2[i_taps.tap_b];
  assign o_all_ones = (&r_g1) & (&r_g2);

endmodule

// File: rtl/gps_ca_code_gen.sv
// C/A code generator: start/capture FSM, chip capture shifter and epoch phase counter.
// state   | meaning
// IDLE    | no valid PRN latched (after reset or an illegal start); chip strobes ignored
// RUN     | capturing chips into ca_code_o
// DONE    | CA_BITS chips captured; word frozen, chip stream keeps running
module gps_ca_code_gen #(
  parameter int CA_BITS  = 13,
  parameter int CODE_LEN = 1023
) (
  input  logic               sys_clk_50,
  input  logic               sync_rst_in,
  input  logic               start_i,
  input  logic [5:0]         sv_num_i,
  input  logic               chip_en_i,
  output logic [CA_BITS-1:0] ca_code_o,
  output logic               done_o,
  output logic               err_o,
  output logic               chip_o,
  output logic               chip_vld_o,
  output logic [9:0]         code_phase_o,
  output logic               epoch_o
);
  import gps_ca_pkg::*;

  localparam int CNT_W = $clog2(CA_BITS + 1);

  state_t             r_state;
  tap_pair_t          r_taps;
  logic [CA_BITS-1:0] r_ca;
  logic [CNT_W-1:0]   r_cnt;
  logic [9:0]         r_phase;
  logic               r_done;
  logic               r_err;
  logic               r_vld;
  logic               r_epoch;

  logic w_prn_ok;
  logic w_load;
  logic w_shift;
  logic w_chip;
  logic w_all_ones;

  assign w_prn_ok = (sv_num_i >= 6'd1) && (sv_num_i <= 6'(MAX_PRN));
  assign w_load   = start_i && w_prn_ok;
  // A start in the same cycle as a strobe takes priority, so that chip is not consumed.
  assign w_shift  = chip_en_i && !start_i && (r_state != ST_IDLE);

  gps_ca_lfsr u_lfsr (
    .i_clk      (sys_clk_50),
    .i_rst      (sync_rst_in),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_taps     (r_taps),
    .o_chip     (w_chip),
    .o_all_ones (w_all_ones)
  );

  always_ff @(posedge sys_clk_50) begin
    if (sync_rst_in) begin
      r_state <= ST_IDLE;
      r_taps  <= prn_taps(6'd1);
      r_ca    <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_vld   <= 1'b0;
      r_epoch <= 1'b0;
    end else begin
      r_epoch <= 1'b0;
      if (start_i) begin
        r_ca   <= '0;
        r_cnt  <= '0;
        r_done <= 1'b0;
        if (w_prn_ok) begin
          r_state <= ST_RUN;
          r_taps  <= prn_taps(sv_num_i);
          r_phase <= '0;
          r_err   <= 1'b0;
          r_vld   <= 1'b1;
        end else begin
          r_state <= ST_IDLE;
          r_err   <= 1'b1;
          r_vld   <= 1'b0;
        end
      end else if (w_shift) begin
        if (r_phase == 10'(CODE_LEN - 1)) begin
          r_phase <= '0;
          r_epoch <= 1'b1;
        end else begin
          r_phase <= r_phase + 10'd1;
        end
        if (r_state == ST_RUN) begin
          r_ca  <= CA_BITS'({r_ca, w_chip});
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(CA_BITS - 1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  // Both registers return to all ones exactly when the 1023-chip epoch wraps.
  always_ff @(posedge sys_clk_50) begin
    if (!sync_rst_in && r_epoch) begin
      assert (w_all_ones);
    end
  end

  assign ca_code_o    = r_ca;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign chip_o       = w_chip;
  assign chip_vld_o   = r_vld;
  assign code_phase_o = r_phase;
  assign epoch_o      = r_epoch;

endmodule

// File: tb/tb_gps_ca_code_gen.sv
// Self-checking bench for gps_ca_code_gen: PRN vector table plus hand-written
// corner sequences; every chip is scored against an independent recurrence model.
module tb_gps_ca_code_gen;

  localparam int CA_BITS = 13;
  localparam int NSEQ    = 1040;

  logic               clk = 1'b0;
  logic               sync_rst_in;
  logic               start_i;
  logic [5:0]         sv_num_i;
  logic               chip_en_i;
  logic [CA_BITS-1:0] ca_code_o;
  logic               done_o;
  logic               err_o;
  logic               chip_o;
  logic               chip_vld_o;
  logic [9:0]         code_phase_o;
  logic               epoch_o;

  gps_ca_code_gen #(.CA_BITS(CA_BITS), .CODE_LEN(1023)) dut (
    .sys_clk_50   (clk),
    .sync_rst_in  (sync_rst_in),
    .start_i      (start_i),
    .sv_num_i     (sv_num_i),
    .chip_en_i    (chip_en_i),
    .ca_code_o    (ca_code_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .chip_o       (chip_o),
    .chip_vld_o   (chip_vld_o),
    .code_phase_o (code_phase_o),
    .epoch_o      (epoch_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // ICD-GPS-200 G2 phase selection, PRN 1..37
  int tap_a [1:37] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4,5,4,1,2,4};
  int tap_b [1:37] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9,10,10,7,8,10};

  bit s1 [NSEQ];
  bit s2 [NSEQ];

  bit exp_q [$];
  int m_prn;
  int m_phase;
  bit m_running;

  typedef struct {
    int         prn;
    bit         legal;
    logic [9:0] exp10;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Output sequences of the two registers: s[n+10] is the new feedback bit.
  task automatic build_model();
    for (int i = 0; i < 10; i++) begin
      s1[i] = 1'b1;
      s2[i] = 1'b1;
    end
    for (int n = 0; n + 10 < NSEQ; n++) begin
      s1[n+10] = s1[n+7] ^ s1[n];
      s2[n+10] = s2[n+8] ^ s2[n+7] ^ s2[n+4] ^ s2[n+2] ^ s2[n+1] ^ s2[n];
    end
  endtask

  function automatic bit model_chip(input int prn, input int n);
    int k;
    k = n % 1023;
    return s1[k] ^ s2[k + 10 - tap_a[prn]] ^ s2[k + 10 - tap_b[prn]];
  endfunction

  function automatic logic [31:0] model_word(input int prn, input int nbits);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < nbits; i++) w = {w[30:0], model_chip(prn, i)};
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    if (m_running) begin
      exp_q.push_back(model_chip(m_prn, m_phase));
      m_phase = (m_phase + 1) % 1023;
    end
    chip_en_i = 1'b1;
    tick();
    chip_en_i = 1'b0;
  endtask

  task automatic do_start(input int prn);
    sv_num_i = 6'(prn);
    start_i  = 1'b1;
    if (prn >= 1 && prn <= 37) begin
      m_prn     = prn;
      m_phase   = 0;
      m_running = 1'b1;
    end else begin
      m_running = 1'b0;
    end
    tick();
    start_i = 1'b0;
  endtask

  // Scoreboard consumer: chip_o is scored in every cycle a strobe is consumed.
  always @(negedge clk) begin
    if (chip_en_i && m_running && !start_i && !sync_rst_in) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk("sb_chip", 32'(chip_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int ep_cnt;
    logic [31:0] w13;

    build_model();
    w13 = model_word(1, CA_BITS);
    vecs[0] = '{1,  1'b1, 10'o1440};
    vecs[1] = '{0,  1'b0, 10'd0};
    vecs[2] = '{2,  1'b1, 10'o1620};
    vecs[3] = '{38, 1'b0, 10'd0};
    vecs[4] = '{3,  1'b1, 10'o1710};
    vecs[5] = '{63, 1'b0, 10'd0};
    vecs[6] = '{37, 1'b1, 10'(model_word(37, 10))};

    m_running   = 1'b0;
    m_prn       = 1;
    m_phase     = 0;
    sync_rst_in = 1'b1;
    start_i     = 1'b0;
    sv_num_i    = '0;
    chip_en_i   = 1'b0;
    tick();
    tick();
    chk("rst_ca",    32'(ca_code_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    chk("rst_vld",   32'(chip_vld_o), 32'd0);
    chk("rst_epoch", 32'(epoch_o), 32'd0);
    chk("rst_phase", 32'(code_phase_o), 32'd0);
    sync_rst_in = 1'b0;
    tick();

    // Strobes in IDLE are ignored.
    repeat (3) strobe();
    chk("idle_phase", 32'(code_phase_o), 32'd0);
    chk("idle_g1", 32'(dut.u_lfsr.r_g1), 32'h3FF);
    chk("idle_g2", 32'(dut.u_lfsr.r_g2), 32'h3FF);

    for (int v = 0; v < 7; v++) begin
      do_start(vecs[v].prn);
      if (vecs[v].legal) begin
        chk("vec_err_clr", 32'(err_o), 32'd0);
        chk("vec_vld",     32'(chip_vld_o), 32'd1);
        chk("vec_ca_clr",  32'(ca_code_o), 32'd0);
        chk("vec_phase0",  32'(code_phase_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
          strobe();
          if ($urandom_range(0, 2) == 0) tick();
        end
        chk("vec_first10", 32'(ca_code_o[9:0]), 32'(vecs[v].exp10));
        chk("vec_phase10", 32'(code_phase_o), 32'd10);
        chk("vec_done0",   32'(done_o), 32'd0);
      end else begin
        chk("bad_err",   32'(err_o), 32'd1);
        chk("bad_vld",   32'(chip_vld_o), 32'd0);
        chk("bad_done",  32'(done_o), 32'd0);
        chk("bad_ca",    32'(ca_code_o), 32'd0);
        chk("bad_state", 32'(dut.r_state), 32'(gps_ca_pkg::ST_IDLE));
        repeat (2) strobe();
        chk("bad_err_hold", 32'(err_o), 32'd1);
        chk("bad_idle",     32'(dut.r_state), 32'(gps_ca_pkg::ST_IDLE));
      end
    end

    // Capture of CA_BITS chips, done latency and freeze in DONE.
    do_start(1);
    repeat (CA_BITS - 1) strobe();
    chk("done_early", 32'(done_o), 32'd0);
    strobe();
    chk("done_rise", 32'(done_o), 32'd1);
    chk("ca_word",   32'(ca_code_o), w13);
    repeat (6) strobe();
    chk("ca_frozen",  32'(ca_code_o), w13);
    chk("done_held",  32'(done_o), 32'd1);
    chk("phase_cont", 32'(code_phase_o), 32'(CA_BITS + 6));

    // Full epoch with irregular strobe spacing.
    do_start(1);
    ep_cnt = 0;
    for (int i = 0; i < 1023; i++) begin
      strobe();
      ep_cnt += int'(epoch_o);
      if (i == 1022) begin
        chk("wrap_epoch", 32'(epoch_o), 32'd1);
        chk("wrap_phase", 32'(code_phase_o), 32'd0);
        chk("wrap_g1",    32'(dut.u_lfsr.r_g1), 32'h3FF);
        chk("wrap_g2",    32'(dut.u_lfsr.r_g2), 32'h3FF);
      end else if ($urandom_range(0, 3) == 0) begin
        tick();
        ep_cnt += int'(epoch_o);
      end
    end
    tick();
    chk("epoch_width", 32'(epoch_o), 32'd0);
    chk("epoch_count", 32'(ep_cnt), 32'd1);
    repeat (5) strobe();
    chk("epoch2_phase", 32'(code_phase_o), 32'd5);

    // Start coincident with a strobe mid-RUN: restart, strobe not consumed.
    do_start(1);
    repeat (5) strobe();
    sv_num_i  = 6'd1;
    start_i   = 1'b1;
    chip_en_i = 1'b1;
    m_phase   = 0;
    tick();
    start_i   = 1'b0;
    chip_en_i = 1'b0;
    chk("coin_phase", 32'(code_phase_o), 32'd0);
    chk("coin_ca",    32'(ca_code_o), 32'd0);
    repeat (CA_BITS) strobe();
    chk("coin_word", 32'(ca_code_o), w13);
    chk("coin_done", 32'(done_o), 32'd1);

    // Reset coincident with a strobe mid-RUN.
    do_start(2);
    repeat (4) strobe();
    sync_rst_in = 1'b1;
    chip_en_i   = 1'b1;
    m_running   = 1'b0;
    tick();
    sync_rst_in = 1'b0;
    chip_en_i   = 1'b0;
    chk("rst2_ca",    32'(ca_code_o), 32'd0);
    chk("rst2_done",  32'(done_o), 32'd0);
    chk("rst2_err",   32'(err_o), 32'd0);
    chk("rst2_vld",   32'(chip_vld_o), 32'd0);
    chk("rst2_epoch", 32'(epoch_o), 32'd0);
    chk("rst2_phase", 32'(code_phase_o), 32'd0);
    do_start(1);
    repeat (CA_BITS) strobe();
    chk("rst2_word", 32'(ca_code_o), w13);
    chk("rst2_done1", 32'(done_o), 32'd1);

    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
